// File: rtl/sparc_core_rtap_sched_pkg.sv
// Shared types and constants for the core-side rtap debug request scheduler.
// Holds the bus widths, the debug unit ids, the FSM encoding and the FIFO entry layout.
package sparc_core_rtap_sched_pkg;

    localparam int CORE_JTAG_BUS_WIDTH = 32;
    localparam int JTAG_CORE_ID_WIDTH  = 4;

    localparam logic [JTAG_CORE_ID_WIDTH-1:0] JTAG_CORE_ID_IFU_SSCAN = 4'd0;
    localparam logic [JTAG_CORE_ID_WIDTH-1:0] JTAG_CORE_ID_TLU       = 4'd1;
    localparam logic [JTAG_CORE_ID_WIDTH-1:0] JTAG_CORE_ID_LSU       = 4'd2;
    localparam logic [JTAG_CORE_ID_WIDTH-1:0] JTAG_CORE_ID_SPU       = 4'd3;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_ISSUE = 2'd1,
        SCHED_WAIT  = 2'd2,
        SCHED_RESP  = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic [1:0]                     threadid;
        logic [JTAG_CORE_ID_WIDTH-1:0]  id;
        logic [CORE_JTAG_BUS_WIDTH-1:0] data;
    } rtap_req_t;

endpackage

// File: rtl/sparc_core_rtap_sched_if.sv
// rtap request/response bus plus the per-unit issue/response lines of the scheduler.
// The slave modport is the scheduler; the master modport is the rtap side and the debug units.
interface sparc_core_rtap_sched_if
    import sparc_core_rtap_sched_pkg::*;
#(
    parameter int NUM_UNITS = 4
);
    logic                                     rtap_core_val;
    logic [1:0]                               rtap_core_threadid;
    logic [JTAG_CORE_ID_WIDTH-1:0]            rtap_core_id;
    logic [CORE_JTAG_BUS_WIDTH-1:0]           rtap_core_data;

    logic [NUM_UNITS-1:0]                     unit_req_val;
    logic [1:0]                               unit_req_threadid;
    logic [CORE_JTAG_BUS_WIDTH-1:0]           unit_req_data;
    logic [NUM_UNITS-1:0]                     unit_rsp_val;
    logic [NUM_UNITS*CORE_JTAG_BUS_WIDTH-1:0] unit_rsp_data;

    logic                                     core_rtap_val;
    logic [CORE_JTAG_BUS_WIDTH-1:0]           core_rtap_data;
    logic                                     core_rtap_err;

    modport slave (
        input  rtap_core_val, rtap_core_threadid, rtap_core_id, rtap_core_data,
        input  unit_rsp_val, unit_rsp_data,
        output unit_req_val, unit_req_threadid, unit_req_data,
        output core_rtap_val, core_rtap_data, core_rtap_err
    );

    modport master (
        output rtap_core_val, rtap_core_threadid, rtap_core_id, rtap_core_data,
        output unit_rsp_val, unit_rsp_data,
        input  unit_req_val, unit_req_threadid, unit_req_data,
        input  core_rtap_val, core_rtap_data, core_rtap_err
    );

endinterface

// File: rtl/sparc_core_rtap_sched_req_fifo.sv
// Two-entry flop FIFO for buffered rtap requests.
// A push while full is still taken when the head is popped in the same cycle.
module sparc_rtap_req_fifo
    import sparc_core_rtap_sched_pkg::*;
(
    input  logic      rclk,
    input  logic      rst_n,
    input  logic      push_i,
    input  rtap_req_t push_data_i,
    input  logic      pop_i,
    output rtap_req_t head_o,
    output logic      push_ok_o,
    output logic      full_o,
    output logic      empty_o
);

    rtap_req_t  mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       pop_ok;

    assign full_o    = (count_q == 2'd2);
    assign empty_o   = (count_q == 2'd0);
    assign push_ok_o = push_i && (!full_o || pop_i);
    assign pop_ok    = pop_i && !empty_o;
    assign head_o    = mem_q[rd_ptr_q];

    // NOTE: the storage array has no reset; only pointers and count define validity,
    // so leaving data flops unreset is safe and keeps them out of the reset tree.
    always_ff @(posedge rclk) begin
        if (push_ok_o) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok_o) wr_ptr_q <= ~wr_ptr_q;
            if (pop_ok)    rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push_ok_o} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/sparc_core_rtap_sched.sv
// Core-side rtap debug scheduler: buffers requests, issues one at a time to the addressed
// debug unit, and returns exactly one response (unit data, or error on bad id/timeout).
module sparc_core_rtap_sched
    import sparc_core_rtap_sched_pkg::*;
#(
    parameter int NUM_UNITS    = 4,
    parameter int UNIT_ID_BASE = int'(JTAG_CORE_ID_IFU_SSCAN),
    parameter int TIMEOUT_CYC  = 16
) (
    input  logic                   rclk,
    input  logic                   rst_n,
    sparc_core_rtap_sched_if.slave bus,
    output logic                   sched_busy,
    output logic                   sched_ovf
);

    localparam int W     = CORE_JTAG_BUS_WIDTH;
    localparam int SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    rtap_req_t    push_data;
    rtap_req_t    fifo_head;
    logic         fifo_pop;
    logic         fifo_push_ok;
    logic         fifo_full;
    logic         fifo_empty;

    sched_state_e         state_q;
    logic [SEL_W-1:0]     sel_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 hit_q;
    logic [W-1:0]         rsp_data_q;
    logic [NUM_UNITS-1:0] unit_req_val_q;
    logic [1:0]           unit_req_tid_q;
    logic [W-1:0]         unit_req_data_q;
    logic                 core_val_q;
    logic [W-1:0]         core_data_q;
    logic                 core_err_q;
    logic                 ovf_q;

    int                   head_off;
    logic                 head_in_range;
    logic [SEL_W-1:0]     sel_d;
    logic                 raw_hit;

    assign push_data = '{threadid: bus.rtap_core_threadid,
                         id:       bus.rtap_core_id,
                         data:     bus.rtap_core_data};
    assign fifo_pop  = (state_q == SCHED_IDLE) && !fifo_empty;

    sparc_rtap_req_fifo u_req_fifo (
        .rclk        (rclk),
        .rst_n       (rst_n),
        .push_i      (bus.rtap_core_val),
        .push_data_i (push_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .push_ok_o   (fifo_push_ok),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign head_off      = int'(fifo_head.id) - UNIT_ID_BASE;
    assign head_in_range = (head_off >= 0) && (head_off < NUM_UNITS);
    assign sel_d         = SEL_W'(head_off);
    assign raw_hit       = bus.unit_rsp_val[sel_q];

    // Unit responses are registered before use (hit_q), so a response seen in the last
    // timeout cycle suppresses the timeout and completes on the following cycle.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= SCHED_IDLE;
            sel_q           <= '0;
            cnt_q           <= '0;
            hit_q           <= 1'b0;
            rsp_data_q      <= '0;
            unit_req_val_q  <= '0;
            unit_req_tid_q  <= '0;
            unit_req_data_q <= '0;
            core_val_q      <= 1'b0;
            core_data_q     <= '0;
            core_err_q      <= 1'b0;
            ovf_q           <= 1'b0;
        end else begin
            // NOTE: strobes default low with non-blocking assignments here and are raised
            // only by the transition that needs them, giving single-cycle registered pulses.
            unit_req_val_q <= '0;
            core_val_q     <= 1'b0;
            core_data_q    <= '0;
            core_err_q     <= 1'b0;
            hit_q          <= 1'b0;

            if (bus.rtap_core_val && !fifo_push_ok) begin
                ovf_q <= 1'b1;
            end

            case (state_q)
                SCHED_IDLE: begin
                    if (!fifo_empty) begin
                        if (head_in_range) begin
                            sel_q           <= sel_d;
                            unit_req_val_q  <= NUM_UNITS'(1) << sel_d;
                            unit_req_tid_q  <= fifo_head.threadid;
                            unit_req_data_q <= fifo_head.data;
                            state_q         <= SCHED_ISSUE;
                        end else begin
                            core_val_q <= 1'b1;
                            core_err_q <= 1'b1;
                            state_q    <= SCHED_RESP;
                        end
                    end
                end
                SCHED_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= SCHED_WAIT;
                end
                SCHED_WAIT: begin
                    if (hit_q) begin
                        core_val_q  <= 1'b1;
                        core_data_q <= rsp_data_q;
                        state_q     <= SCHED_RESP;
                    end else if (raw_hit) begin
                        hit_q      <= 1'b1;
                        rsp_data_q <= bus.unit_rsp_data[sel_q*W +: W];
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        core_val_q <= 1'b1;
                        core_err_q <= 1'b1;
                        state_q    <= SCHED_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SCHED_RESP: begin
                    state_q <= SCHED_IDLE;
                end
                default: state_q <= SCHED_IDLE;
            endcase
        end
    end

    assign bus.unit_req_val      = unit_req_val_q;
    assign bus.unit_req_threadid = unit_req_tid_q;
    assign bus.unit_req_data     = unit_req_data_q;
    assign bus.core_rtap_val     = core_val_q;
    assign bus.core_rtap_data    = core_data_q;
    assign bus.core_rtap_err     = core_err_q;
    assign sched_busy            = (state_q != SCHED_IDLE) || !fifo_empty;
    assign sched_ovf             = ovf_q;

endmodule
